// File: rtl/ring_osc_meter_ctrl.sv
// rtl/ring_osc_meter_ctrl.sv - ring oscillator measurement sequencer (enable, settle, clear, windowed edge count)
module ring_osc_meter_ctrl #(
   parameter int CW      = 8,
   parameter int RW      = 24,
   parameter int WINDOW  = 48000,
   parameter int SETTLE  = 64,
   parameter int CLR_CYC = 8
) (
   input  logic          clk48,
   input  logic          rst_n,
   input  logic          start,
   input  logic          cont,
   input  logic          stop,
   input  logic [CW-1:0] ring_gray,
   output logic          osc_en,
   output logic          cnt_clr,
   output logic          busy,
   output logic          done,
   output logic [RW-1:0] result,
   output logic          overflow
);

   localparam int SW    = ((RW > CW) ? RW : CW) + 1;
   localparam int MAXC0 = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int MAXC1 = (MAXC0 > CLR_CYC) ? MAXC0 : CLR_CYC;
   localparam int MAXC  = (MAXC1 > 4) ? MAXC1 : 4;
   localparam int TW    = $clog2(MAXC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ENABLE,
      S_CLEAR,
      S_ARM,
      S_MEASURE,
      S_DONE
   } state_t;

   state_t        state;
   logic [TW-1:0] cnt;
   logic [CW-1:0] sync1;
   logic [CW-1:0] sync2;
   logic [CW-1:0] bin_s;
   logic [CW-1:0] prev;
   logic [CW-1:0] delta;
   logic [RW-1:0] acc;
   logic          ovf_int;
   logic [SW-1:0] sum;
   logic          sat;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin_s = '0;
      for (int i = 0; i < CW; i++) begin
         bin_s[i] = ^(sync2 >> i);
      end
   end

   // Modulo subtraction makes ring counter wrap-around transparent.
   assign delta = bin_s - prev;
   assign sum   = SW'(acc) + SW'(delta);
   assign sat   = (sum > SW'({RW{1'b1}}));

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cnt      <= '0;
         sync1    <= '0;
         sync2    <= '0;
         prev     <= '0;
         acc      <= '0;
         ovf_int  <= 1'b0;
         osc_en   <= 1'b0;
         cnt_clr  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
         overflow <= 1'b0;
      end else begin
         sync1 <= ring_gray;
         sync2 <= sync1;
         done  <= 1'b0;
         if (state != S_IDLE && stop) begin
            state   <= S_IDLE;
            cnt     <= '0;
            osc_en  <= 1'b0;
            cnt_clr <= 1'b0;
            busy    <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  osc_en  <= 1'b0;
                  cnt_clr <= 1'b0;
                  busy    <= 1'b0;
                  if (start && !stop) begin
                     state <= S_ENABLE;
                     cnt   <= '0;
                  end
               end
               S_ENABLE: begin
                  osc_en  <= 1'b1;
                  cnt_clr <= 1'b0;
                  busy    <= 1'b1;
                  if (cnt == TW'(SETTLE - 1)) begin
                     state <= S_CLEAR;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_CLEAR: begin
                  osc_en  <= 1'b1;
                  cnt_clr <= 1'b1;
                  busy    <= 1'b1;
                  if (cnt == TW'(CLR_CYC - 1)) begin
                     state <= S_ARM;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_ARM: begin
                  osc_en  <= 1'b1;
                  cnt_clr <= 1'b0;
                  busy    <= 1'b1;
                  // Synchronizer latency is flushed by now; snapshot the baseline.
                  if (cnt == TW'(3)) begin
                     state   <= S_MEASURE;
                     cnt     <= '0;
                     prev    <= bin_s;
                     acc     <= '0;
                     ovf_int <= 1'b0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_MEASURE: begin
                  osc_en  <= 1'b1;
                  cnt_clr <= 1'b0;
                  busy    <= 1'b1;
                  prev    <= bin_s;
                  if (sat) begin
                     acc     <= {RW{1'b1}};
                     ovf_int <= 1'b1;
                  end else begin
                     acc <= sum[RW-1:0];
                  end
                  if (cnt == TW'(WINDOW - 1)) begin
                     state <= S_DONE;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               S_DONE: begin
                  result   <= acc;
                  overflow <= ovf_int;
                  done     <= 1'b1;
                  cnt_clr  <= 1'b0;
                  cnt      <= '0;
                  // prev is kept so edges seen during this cycle land in the next window.
                  if (cont) begin
                     state   <= S_MEASURE;
                     acc     <= '0;
                     ovf_int <= 1'b0;
                     osc_en  <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     osc_en <= 1'b0;
                     busy   <= 1'b0;
                  end
               end
               default: begin
                  state   <= S_IDLE;
                  cnt     <= '0;
                  osc_en  <= 1'b0;
                  cnt_clr <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ring_osc_meter_ctrl.sv
// tb/tb_ring_osc_meter_ctrl.sv - directed self-checking bench for ring_osc_meter_ctrl
`timescale 1ns/1ps
module tb_ring_osc_meter_ctrl;

   logic        clk48 = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        cont  = 1'b0;
   logic        stop  = 1'b0;
   logic [7:0]  ring_gray = '0;

   logic        osc_en_a, cnt_clr_a, busy_a, done_a, overflow_a;
   logic [11:0] result_a;
   logic        osc_en_b, cnt_clr_b, busy_b, done_b, overflow_b;
   logic [5:0]  result_b;

   int n_cmp  = 0;
   int n_fail = 0;
   int edge_no = 0;

   logic [7:0] ring_cnt = '0;
   logic [7:0] clr_val  = '0;
   int         k  = 4;
   int         ph = 0;

   ring_osc_meter_ctrl #(.CW(8), .RW(12), .WINDOW(100), .SETTLE(8), .CLR_CYC(2)) dut_a (
      .clk48(clk48), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
      .ring_gray(ring_gray), .osc_en(osc_en_a), .cnt_clr(cnt_clr_a), .busy(busy_a),
      .done(done_a), .result(result_a), .overflow(overflow_a)
   );

   ring_osc_meter_ctrl #(.CW(8), .RW(6), .WINDOW(100), .SETTLE(8), .CLR_CYC(2)) dut_b (
      .clk48(clk48), .rst_n(rst_n), .start(start), .cont(cont), .stop(stop),
      .ring_gray(ring_gray), .osc_en(osc_en_b), .cnt_clr(cnt_clr_b), .busy(busy_b),
      .done(done_b), .result(result_b), .overflow(overflow_b)
   );

   always #10 clk48 = ~clk48;

   // Ring-domain counter model: steps every k cycles, held at clr_val while cleared.
   initial begin
      forever begin
         @(negedge clk48);
         if (cnt_clr_a) begin
            ring_cnt = clr_val;
            ph = 0;
         end else begin
            ph = ph + 1;
            if (ph >= k) begin
               ring_cnt = ring_cnt + 8'd1;
               ph = 0;
            end
         end
         ring_gray = ring_cnt ^ (ring_cnt >> 1);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk48);
      edge_no++;
      #1;
   endtask

   task automatic run_to(input int e);
      while (edge_no < e) tick();
   endtask

   task automatic go_start();
      start = 1'b1;
      @(posedge clk48);
      edge_no = 0;
      #1;
      start = 1'b0;
   endtask

   task automatic idle_gap();
      repeat (3) tick();
   endtask

   int done_seen;
   int w1, w2, w3;

   initial begin
      // Reset state
      repeat (3) tick();
      check("reset_outputs_a", {osc_en_a, cnt_clr_a, busy_a, done_a, overflow_a, result_a}, 0);
      check("reset_outputs_b", {osc_en_b, cnt_clr_b, busy_b, done_b, overflow_b, result_b}, 0);
      @(negedge clk48);
      rst_n = 1'b1;
      idle_gap();
      check("idle_busy", busy_a, 0);

      // Single shot, k=4
      k = 4; clr_val = 8'd0;
      go_start();
      check("e0_osc_en", osc_en_a, 0);
      check("e0_busy", busy_a, 0);
      run_to(1);
      check("e1_osc_en", osc_en_a, 1);
      check("e1_busy", busy_a, 1);
      run_to(8);
      check("e8_cnt_clr", cnt_clr_a, 0);
      run_to(9);
      check("e9_cnt_clr", cnt_clr_a, 1);
      run_to(10);
      check("e10_cnt_clr", cnt_clr_a, 1);
      run_to(11);
      check("e11_cnt_clr", cnt_clr_a, 0);
      check("e11_osc_en", osc_en_a, 1);
      run_to(114);
      check("e114_done", done_a, 0);
      run_to(115);
      check("e115_done", done_a, 1);
      check("single_result", result_a, 25);
      check("single_overflow", overflow_a, 0);
      check("e115_busy", busy_a, 0);
      run_to(116);
      check("e116_done", done_a, 0);
      check("e116_osc_en", osc_en_a, 0);
      idle_gap();

      // Counter wrap and saturation, k=1, preload 200
      k = 1; clr_val = 8'd200;
      go_start();
      run_to(115);
      check("wrap_done", done_a, 1);
      check("wrap_result", result_a, 100);
      check("wrap_overflow", overflow_a, 0);
      check("sat_done", done_b, 1);
      check("sat_result", result_b, 63);
      check("sat_overflow", overflow_b, 1);
      idle_gap();

      // Abort at edge 50: no done, results held
      k = 4; clr_val = 8'd0;
      go_start();
      run_to(49);
      stop = 1'b1;
      run_to(50);
      stop = 1'b0;
      run_to(51);
      check("abort_busy", busy_a, 0);
      check("abort_osc_en", osc_en_a, 0);
      done_seen = 0;
      while (edge_no < 59) begin
         tick();
         if (done_a || done_b) done_seen = 1;
      end
      check("abort_no_done", done_seen, 0);
      check("abort_result_held", result_a, 100);
      check("abort_result_held_b", result_b, 63);
      check("abort_overflow_held_b", overflow_b, 1);

      // Restart after abort, k=4: saturating instance recovers
      go_start();
      run_to(115);
      check("restart_done", done_a, 1);
      check("restart_result", result_a, 25);
      check("restart_result_b", result_b, 25);
      check("restart_overflow_b", overflow_b, 0);
      idle_gap();

      // Continuous mode, k=2
      k = 2; cont = 1'b1;
      go_start();
      run_to(114);
      check("cont_e114_done", done_a, 0);
      run_to(115);
      check("cont_done1", done_a, 1);
      w1 = int'(result_a);
      check("cont_w1", result_a, 50);
      run_to(215);
      check("cont_e215_done", done_a, 0);
      run_to(216);
      check("cont_done2", done_a, 1);
      w2 = int'(result_a);
      check("cont_w2_range", 32'(w2 >= 49 && w2 <= 51), 1);
      cont = 1'b0;
      run_to(317);
      check("cont_done3", done_a, 1);
      w3 = int'(result_a);
      check("cont_w3_range", 32'(w3 >= 49 && w3 <= 51), 1);
      check("cont_sum", w1 + w2 + w3, 151);
      run_to(318);
      check("cont_end_busy", busy_a, 0);
      idle_gap();

      // Reset mid-measure, then restart with an ignored start during busy
      k = 4;
      go_start();
      run_to(70);
      rst_n = 1'b0;
      #1;
      check("async_reset_a", {osc_en_a, cnt_clr_a, busy_a, done_a, overflow_a, result_a}, 0);
      check("async_reset_b", {osc_en_b, cnt_clr_b, busy_b, done_b, overflow_b, result_b}, 0);
      @(negedge clk48);
      rst_n = 1'b1;
      idle_gap();
      check("post_reset_idle", busy_a, 0);
      go_start();
      run_to(29);
      start = 1'b1;
      run_to(30);
      start = 1'b0;
      run_to(115);
      check("post_reset_done", done_a, 1);
      check("post_reset_result", result_a, 25);
      run_to(118);
      check("ignored_start_busy", busy_a, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
